// File: rtl/page_nway_leaf_mux.sv
// NUM_CH-way BFT leaf mux: routes downstream packets to child pages and
// round-robin merges per-channel upstream FIFOs. Define PAGE_MUX_STATS_EN for drop_cnt.
module page_nway_leaf_mux #(
    parameter int NUM_CH     = 4,
    parameter int PKT_W      = 49,
    parameter int CH_LSB     = 43,
    parameter int CH_SEL_W   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PKT_W-1:0]        din_leaf_bft2interface,
    output logic [PKT_W-1:0]        dout_leaf_interface2bft,
    input  logic                    resend,
    input  logic [NUM_CH-1:0]       ap_start,
    input  logic [NUM_CH*PKT_W-1:0] ch_din,
    output logic [NUM_CH-1:0]       ch_full,
    output logic [NUM_CH*PKT_W-1:0] ch_dout,
    output logic [NUM_CH-1:0]       ch_started
`ifdef PAGE_MUX_STATS_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);

    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, RESEND} arb_state_e;

    // ---------------- downstream steering ----------------
    logic [CH_SEL_W-1:0]     down_sel;
    logic                    down_valid;
    logic [NUM_CH*PKT_W-1:0] ch_dout_d;

    assign down_sel   = din_leaf_bft2interface[CH_LSB +: CH_SEL_W];
    assign down_valid = din_leaf_bft2interface[PKT_W-1];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ch_dout_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (down_valid && down_sel == CH_SEL_W'(i)) begin
                ch_dout_d[i*PKT_W +: PKT_W] = din_leaf_bft2interface;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_dout    <= '0;
            ch_started <= '0;
        end else begin
            ch_dout    <= ch_dout_d;
            ch_started <= ch_started | ap_start;
        end
    end

    // ---------------- upstream FIFOs ----------------
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] eligible;
    logic [PKT_W-1:0]  head [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        logic [PKT_W-1:0] mem [FIFO_DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    count;
        logic [CW-1:0]    count_d;
        logic             full_q;
        logic             in_valid;

        assign in_valid    = ch_din[g*PKT_W + PKT_W - 1];
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        assign push[g]     = in_valid && (!full_q || pop[g]);
        assign eligible[g] = (count != '0) && ch_started[g];
        assign head[g]     = mem[rd_ptr];
        assign ch_full[g]  = full_q;

        always_comb begin
            count_d = count;
            if (push[g] && !pop[g]) count_d = count + CW'(1);
            else if (!push[g] && pop[g]) count_d = count - CW'(1);
        end

        // NOTE: storage is not reset; only pointers and count define what is valid.
        always_ff @(posedge clk) begin
            if (push[g]) mem[wr_ptr] <= ch_din[g*PKT_W +: PKT_W];
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                full_q <= 1'b0;
            end else begin
                wr_ptr <= wr_ptr + AW'(push[g]);
                rd_ptr <= rd_ptr + AW'(pop[g]);
                count  <= count_d;
                full_q <= (count_d == CW'(FIFO_DEPTH));
            end
        end
    end

    // ---------------- round-robin arbiter ----------------
    arb_state_e       state_q, state_d;
    logic [RR_W-1:0]  rr_q, rr_d;
    logic [RR_W-1:0]  grant;
    logic             found;
    logic             do_sel;
    logic [PKT_W-1:0] out_q, out_d;

    always_comb begin : scan
        int              idx;
        logic [RR_W-1:0] cand;
        found = 1'b0;
        grant = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx  = (int'(rr_q) + off) % NUM_CH;
            cand = RR_W'(idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // resend only stalls while a packet is on the wire; IDLE ignores it.
    assign do_sel = (state_q == IDLE) || !resend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= RR_W'(NUM_CH - 1);
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = found ? SEND : IDLE;
            SEND, RESEND: state_d = resend ? RESEND : (found ? SEND : IDLE);
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d = out_q;
        rr_d  = rr_q;
        pop   = '0;
        if (do_sel) begin
            if (found) begin
                pop[grant] = 1'b1;
                out_d      = head[grant];
                rr_d       = grant;
            end else begin
                out_d = '0;
            end
        end
    end

    assign dout_leaf_interface2bft = out_q;

`ifdef PAGE_MUX_STATS_EN
    // ---------------- drop statistics ----------------
    logic [4:0]  drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        drop_inc = '0;
        if (down_valid && ch_dout_d == '0) drop_inc = 5'd1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_din[i*PKT_W + PKT_W - 1] && ch_full[i] && !pop[i]) begin
                drop_inc = drop_inc + 5'd1;
            end
        end
        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else       drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_page_nway_leaf_mux.sv
// Directed bench for page_nway_leaf_mux: routing, round-robin order, resend,
// start gating, FIFO overflow and asynchronous reset.
module tb_page_nway_leaf_mux;

    localparam int NUM_CH = 4;
    localparam int PKT_W  = 49;

    logic                    clk;
    logic                    reset;
    logic [PKT_W-1:0]        din_leaf_bft2interface;
    logic [PKT_W-1:0]        dout_leaf_interface2bft;
    logic                    resend;
    logic [NUM_CH-1:0]       ap_start;
    logic [NUM_CH*PKT_W-1:0] ch_din;
    logic [NUM_CH-1:0]       ch_full;
    logic [NUM_CH*PKT_W-1:0] ch_dout;
    logic [NUM_CH-1:0]       ch_started;
`ifdef PAGE_MUX_STATS_EN
    logic [15:0]             drop_cnt;
`endif

    page_nway_leaf_mux dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_bft2interface  (din_leaf_bft2interface),
        .dout_leaf_interface2bft (dout_leaf_interface2bft),
        .resend                  (resend),
        .ap_start                (ap_start),
        .ch_din                  (ch_din),
        .ch_full                 (ch_full),
        .ch_dout                 (ch_dout),
        .ch_started              (ch_started)
`ifdef PAGE_MUX_STATS_EN
        ,
        .drop_cnt                (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [PKT_W-1:0] mk(input int sel, input logic [31:0] data);
        logic [PKT_W-1:0] p;
        p          = '0;
        p[PKT_W-1] = 1'b1;
        p[44:43]   = sel[1:0];
        p[31:0]    = data;
        return p;
    endfunction

    function automatic logic [NUM_CH*PKT_W-1:0] slot(input int ch, input logic [PKT_W-1:0] p);
        logic [NUM_CH*PKT_W-1:0] v;
        v = '0;
        v[ch*PKT_W +: PKT_W] = p;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int ch, input logic [PKT_W-1:0] p);
        ch_din[ch*PKT_W +: PKT_W] = p;
    endtask

    task automatic do_reset();
        reset                  = 1'b1;
        din_leaf_bft2interface = '0;
        ch_din                 = '0;
        resend                 = 1'b0;
        ap_start               = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [PKT_W-1:0] p;
    logic [PKT_W-1:0] q [4];

    initial begin
        // ---- reset state and downstream routing ----
        do_reset();
        check("rst_dout", dout_leaf_interface2bft, '0);
        check("rst_ch_dout", ch_dout, '0);
        check("rst_full", ch_full, '0);
        check("rst_started", ch_started, '0);

        p = mk(2, 32'hA5A5_0001);
        din_leaf_bft2interface = p;
        tick();
        check("route_ch2", ch_dout, slot(2, p));
        p = mk(3, 32'hA5A5_0003);
        din_leaf_bft2interface = p;
        tick();
        check("route_ch3", ch_dout, slot(3, p));
        p = mk(0, 32'hA5A5_0000);
        din_leaf_bft2interface = p;
        tick();
        check("route_ch0", ch_dout, slot(0, p));
        p = mk(1, 32'hA5A5_0002);
        p[PKT_W-1] = 1'b0;
        din_leaf_bft2interface = p;
        tick();
        check("route_invalid", ch_dout, '0);
        din_leaf_bft2interface = '0;

        // ---- round-robin order, all channels pushed together ----
        ap_start = 4'hF;
        tick();
        ap_start = '0;
        check("started_all", ch_started, 4'hF);
        for (int i = 0; i < 4; i++) begin
            q[i] = mk(i, 32'h1000_0000 + i);
            put(i, q[i]);
        end
        tick();
        ch_din = '0;
        check("rr_latency_gap", dout_leaf_interface2bft, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_order_%0d", i), dout_leaf_interface2bft, q[i]);
        end
        tick();
        check("rr_drained", dout_leaf_interface2bft, '0);

        // ---- resend holds the ch1 packet for three extra cycles ----
        for (int i = 0; i < 4; i++) begin
            q[i] = mk(i, 32'h2000_0000 + i);
            put(i, q[i]);
        end
        tick();
        ch_din = '0;
        tick();
        check("rs_ch0", dout_leaf_interface2bft, q[0]);
        tick();
        check("rs_ch1", dout_leaf_interface2bft, q[1]);
        resend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rs_hold_%0d", i), dout_leaf_interface2bft, q[1]);
        end
        resend = 1'b0;
        tick();
        check("rs_ch2", dout_leaf_interface2bft, q[2]);
        tick();
        check("rs_ch3", dout_leaf_interface2bft, q[3]);
        tick();
        check("rs_drained", dout_leaf_interface2bft, '0);

        // ---- start gating on channel 3 ----
        do_reset();
        ap_start = 4'b0111;
        tick();
        ap_start = '0;
        p = mk(3, 32'h3333_0003);
        put(3, p);
        tick();
        ch_din = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gate_blocked_%0d", i), dout_leaf_interface2bft, '0);
        end
        ap_start = 4'b1000;
        tick();
        ap_start = '0;
        tick();
        check("gate_released", dout_leaf_interface2bft, p);
        check("gate_started", ch_started, 4'hF);
        tick();
        check("gate_drained", dout_leaf_interface2bft, '0);

        // ---- overflow while the arbiter is stalled in RESEND ----
        p = mk(1, 32'h3000_00AA);
        put(1, p);
        tick();
        ch_din = '0;
        tick();
        check("ovf_held_pkt", dout_leaf_interface2bft, p);
        resend = 1'b1;
        for (int k = 0; k < 6; k++) begin
            put(0, mk(0, 32'h4000_0000 + k));
            tick();
            check($sformatf("ovf_hold_%0d", k), dout_leaf_interface2bft, p);
            if (k == 2) check("ovf_not_full_3", ch_full, 4'b0000);
            if (k == 3) check("ovf_full_4", ch_full, 4'b0001);
        end
        ch_din = '0;
        check("ovf_full_after_loss", ch_full, 4'b0001);
`ifdef PAGE_MUX_STATS_EN
        check("ovf_drop_cnt", drop_cnt, 16'd2);
`endif
        resend = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("ovf_emit_%0d", k), dout_leaf_interface2bft, mk(0, 32'h4000_0000 + k));
        end
        check("ovf_full_clear", ch_full, 4'b0000);
        tick();
        check("ovf_no_extra", dout_leaf_interface2bft, '0);

        // ---- asynchronous reset in the middle of RESEND ----
        p = mk(2, 32'h5000_0002);
        put(2, p);
        tick();
        ch_din = '0;
        tick();
        check("ar_send", dout_leaf_interface2bft, p);
        resend = 1'b1;
        tick();
        check("ar_resend", dout_leaf_interface2bft, p);
        #2;
        reset = 1'b1;
        #1;
        check("ar_out_async", dout_leaf_interface2bft, '0);
        check("ar_started_async", ch_started, '0);
        tick();
        reset  = 1'b0;
        resend = 1'b0;
        tick();
        check("ar_no_reemit_0", dout_leaf_interface2bft, '0);
        tick();
        check("ar_no_reemit_1", dout_leaf_interface2bft, '0);
        ap_start = 4'hF;
        tick();
        ap_start = '0;
        q[0] = mk(0, 32'h6000_0000);
        q[3] = mk(3, 32'h6000_0003);
        put(0, q[0]);
        put(3, q[3]);
        tick();
        ch_din = '0;
        tick();
        check("ar_prio_ch0", dout_leaf_interface2bft, q[0]);
        tick();
        check("ar_then_ch3", dout_leaf_interface2bft, q[3]);
        tick();
        check("ar_drained", dout_leaf_interface2bft, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
